// File: rtl/gateway_cmd_parser.sv
// Decodes framed UART read/write commands into single RC requests and
// serialises the RC reply ('K', 'D'+data or 'E' on timeout) back to UART.
module gateway_cmd_parser #(
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        rx_byte,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic [7:0]        tx_byte,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              rc_req_valid,
  output logic              rc_req_opcode,
  output logic [ADDR_W-1:0] rc_req_address,
  output logic [DATA_W-1:0] rc_req_data,
  input  logic              rc_req_ready,
  input  logic              rc_rsp_valid,
  input  logic [DATA_W-1:0] rc_rsp_data,
  output logic              busy,
  output logic [7:0]        err_count
);

  localparam int unsigned TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  // Timeout fires on the cycle the counter would step onto TIMEOUT_CYCLES-1.
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 2);

  localparam logic [7:0] CH_R = 8'h52;
  localparam logic [7:0] CH_W = 8'h57;
  localparam logic [7:0] CH_K = 8'h4B;
  localparam logic [7:0] CH_D = 8'h44;
  localparam logic [7:0] CH_E = 8'h45;

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_DATA, S_REQ, S_WAIT, S_SEND
  } state_e;

  state_e              state_q, state_d;
  logic [2:0]          cnt_q, cnt_d;
  logic                opcode_q, opcode_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [DATA_W-1:0]   reply_q, reply_d;
  logic [TW-1:0]       tmo_q, tmo_d;
  logic                req_valid_q, req_valid_d;
  logic                tx_valid_q, tx_valid_d;
  logic [7:0]          tx_byte_q, tx_byte_d;
  logic [7:0]          err_q, err_d;
  logic                rx_ready_q, rx_ready_d;
  logic                busy_q, busy_d;
  logic                rx_hs;

  assign rx_hs = rx_valid & rx_ready_q;

  // Next-state and registered-output decode.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    opcode_d    = opcode_q;
    addr_d      = addr_q;
    data_d      = data_q;
    reply_d     = reply_q;
    tmo_d       = tmo_q;
    req_valid_d = req_valid_q;
    tx_valid_d  = tx_valid_q;
    tx_byte_d   = tx_byte_q;
    err_d       = err_q;

    case (state_q)
      S_IDLE: begin
        if (rx_hs) begin
          if (rx_byte == CH_R || rx_byte == CH_W) begin
            opcode_d = (rx_byte == CH_W);
            addr_d   = '0;
            data_d   = '0;
            cnt_d    = 3'd0;
            state_d  = S_ADDR;
          end else if (err_q != 8'hFF) begin
            err_d = err_q + 8'd1;
          end
        end
      end
      S_ADDR: begin
        if (rx_hs) begin
          addr_d = {addr_q[ADDR_W-9:0], rx_byte};
          cnt_d  = cnt_q + 3'd1;
          if (cnt_q == 3'd3) begin
            cnt_d = 3'd0;
            if (opcode_q) begin
              state_d = S_DATA;
            end else begin
              state_d     = S_REQ;
              req_valid_d = 1'b1;
            end
          end
        end
      end
      S_DATA: begin
        if (rx_hs) begin
          data_d = {data_q[DATA_W-9:0], rx_byte};
          cnt_d  = cnt_q + 3'd1;
          if (cnt_q == 3'd3) begin
            cnt_d       = 3'd0;
            state_d     = S_REQ;
            req_valid_d = 1'b1;
          end
        end
      end
      S_REQ: begin
        if (req_valid_q && rc_req_ready) begin
          req_valid_d = 1'b0;
          tmo_d       = '0;
          state_d     = S_WAIT;
        end
      end
      S_WAIT: begin
        // A response in the same cycle as the timeout takes priority.
        if (rc_rsp_valid) begin
          tx_valid_d = 1'b1;
          state_d    = S_SEND;
          if (opcode_q) begin
            tx_byte_d = CH_K;
            cnt_d     = 3'd0;
          end else begin
            tx_byte_d = CH_D;
            reply_d   = rc_rsp_data;
            cnt_d     = 3'd4;
          end
        end else if (tmo_q == TMO_LAST) begin
          tx_valid_d = 1'b1;
          tx_byte_d  = CH_E;
          cnt_d      = 3'd0;
          state_d    = S_SEND;
          if (err_q != 8'hFF) err_d = err_q + 8'd1;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      S_SEND: begin
        // cnt_q holds the number of reply bytes still to follow.
        if (tx_valid_q && tx_ready) begin
          if (cnt_q == 3'd0) begin
            tx_valid_d = 1'b0;
            state_d    = S_IDLE;
          end else begin
            tx_byte_d = reply_q[DATA_W-1 -: 8];
            reply_d   = {reply_q[DATA_W-9:0], 8'h00};
            cnt_d     = cnt_q - 3'd1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    rx_ready_d = (state_d == S_IDLE) || (state_d == S_ADDR) || (state_d == S_DATA);
    busy_d     = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= 3'd0;
      opcode_q    <= 1'b0;
      addr_q      <= '0;
      data_q      <= '0;
      reply_q     <= '0;
      tmo_q       <= '0;
      req_valid_q <= 1'b0;
      tx_valid_q  <= 1'b0;
      tx_byte_q   <= 8'h00;
      err_q       <= 8'h00;
      rx_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      opcode_q    <= opcode_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      reply_q     <= reply_d;
      tmo_q       <= tmo_d;
      req_valid_q <= req_valid_d;
      tx_valid_q  <= tx_valid_d;
      tx_byte_q   <= tx_byte_d;
      err_q       <= err_d;
      rx_ready_q  <= rx_ready_d;
      busy_q      <= busy_d;
    end
  end

  assign rx_ready       = rx_ready_q;
  assign tx_byte        = tx_byte_q;
  assign tx_valid       = tx_valid_q;
  assign rc_req_valid   = req_valid_q;
  assign rc_req_opcode  = opcode_q;
  assign rc_req_address = addr_q;
  assign rc_req_data    = data_q;
  assign busy           = busy_q;
  assign err_count      = err_q;

endmodule
